// File: rtl/rv32im_decode_execute.sv
// RV32IM instruction decode, ID/EX control register and execute stage (ALU + branch compare).
// Optional M extension enabled by defining RV32M_EN.
module rv32im_decode_execute (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic [31:0] INSTRUCTION,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  input  logic [31:0] PC_EX,
  input  logic [31:0] IMM_EX,
  output logic [3:0]  IMM_SELECT,
  output logic [31:0] ALU_OUT,
  output logic        BRANCH_TAKEN,
  output logic [3:0]  MEM_READ_EX,
  output logic [2:0]  MEM_WRITE_EX,
  output logic        REG_WRITE_EN_EX,
  output logic [1:0]  REG_WRITE_SEL_EX
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SHW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] IMM_NONE = 4'b0000;
  localparam logic [3:0] IMM_I    = 4'b0001;
  localparam logic [3:0] IMM_S    = 4'b0010;
  localparam logic [3:0] IMM_B    = 4'b0011;
  localparam logic [3:0] IMM_U    = 4'b0100;
  localparam logic [3:0] IMM_J    = 4'b0101;

  localparam logic [3:0] BR_JUMP  = 4'b1010;

  localparam logic [1:0] WSEL_MEM = 2'b00;
  localparam logic [1:0] WSEL_ALU = 2'b01;
  localparam logic [1:0] WSEL_PC  = 2'b11;

  typedef struct packed {
    logic [5:0] alu_sel;   // {M, ALT, FWD, funct3}
    logic       op1_sel;
    logic       op2_sel;
    logic [3:0] br_sel;
    logic [3:0] mem_read;
    logic [2:0] mem_write;
    logic       reg_we;
    logic [1:0] reg_wsel;
  } ctrl_t;

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];
  // Register indices are consumed by the register file, not here.
  assign unused_instr_bits = ^{INSTRUCTION[11:7], INSTRUCTION[24:15]};

  // ID: opcode decode into EX/MEM/WB controls; unknown opcodes become a bubble
  always_comb begin
    id_ctrl    = '0;
    IMM_SELECT = IMM_NONE;
    case (opcode)
      OPC_LUI: begin
        id_ctrl.alu_sel  = 6'b001000;
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_ALU;
        IMM_SELECT       = IMM_U;
      end
      OPC_AUIPC: begin
        id_ctrl.op1_sel  = 1'b1;
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_ALU;
        IMM_SELECT       = IMM_U;
      end
      OPC_JAL: begin
        id_ctrl.op1_sel  = 1'b1;
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.br_sel   = BR_JUMP;
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_PC;
        IMM_SELECT       = IMM_J;
      end
      OPC_JALR: begin
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.br_sel   = BR_JUMP;
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_PC;
        IMM_SELECT       = IMM_I;
      end
      OPC_BRANCH: begin
        id_ctrl.op1_sel = 1'b1;
        id_ctrl.op2_sel = 1'b1;
        id_ctrl.br_sel  = {1'b1, funct3};
        IMM_SELECT      = IMM_B;
      end
      OPC_LOAD: begin
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.mem_read = {1'b1, funct3};
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_MEM;
        IMM_SELECT       = IMM_I;
      end
      OPC_STORE: begin
        id_ctrl.op2_sel   = 1'b1;
        id_ctrl.mem_write = {1'b1, funct3[1:0]};
        IMM_SELECT        = IMM_S;
      end
      OPC_OPIMM: begin
        id_ctrl.alu_sel  = {1'b0, (funct3 == 3'b101) & funct7[5], 1'b0, funct3};
        id_ctrl.op2_sel  = 1'b1;
        id_ctrl.reg_we   = 1'b1;
        id_ctrl.reg_wsel = WSEL_ALU;
        IMM_SELECT       = IMM_I;
      end
      OPC_OP: begin
        if (funct7 == 7'b0000001) begin
`ifdef RV32M_EN
          id_ctrl.alu_sel  = {3'b100, funct3};
          id_ctrl.reg_we   = 1'b1;
          id_ctrl.reg_wsel = WSEL_ALU;
`endif
        end else begin
          id_ctrl.alu_sel  = {1'b0, funct7[5], 1'b0, funct3};
          id_ctrl.reg_we   = 1'b1;
          id_ctrl.reg_wsel = WSEL_ALU;
        end
      end
      default: ;
    endcase
  end

  // ID/EX register: stall holds, a taken branch/jump squashes the incoming decode
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_ctrl <= '0;
    end else if (STALL) begin
      ex_ctrl <= ex_ctrl;
    end else if (BRANCH_TAKEN) begin
      ex_ctrl <= '0;
    end else begin
      ex_ctrl <= id_ctrl;
    end
  end

  assign MEM_READ_EX      = ex_ctrl.mem_read;
  assign MEM_WRITE_EX     = ex_ctrl.mem_write;
  assign REG_WRITE_EN_EX  = ex_ctrl.reg_we;
  assign REG_WRITE_SEL_EX = ex_ctrl.reg_wsel;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [SHW-1:0]  shamt;
  logic [2:0]      ex_f3;

  assign op_a  = ex_ctrl.op1_sel ? PC_EX  : RS1_DATA;
  assign op_b  = ex_ctrl.op2_sel ? IMM_EX : RS2_DATA;
  assign shamt = op_b[SHW-1:0];
  assign ex_f3 = ex_ctrl.alu_sel[2:0];

`ifdef RV32M_EN
  logic [2*XLEN-1:0] mul_ss;
  logic [2*XLEN-1:0] mul_su;
  logic [2*XLEN-1:0] mul_uu;
  logic              div_zero;
  logic              div_ovf;

  assign mul_ss   = $signed({{XLEN{op_a[XLEN-1]}}, op_a}) * $signed({{XLEN{op_b[XLEN-1]}}, op_b});
  assign mul_su   = $signed({{XLEN{op_a[XLEN-1]}}, op_a}) * $signed({{XLEN{1'b0}}, op_b});
  assign mul_uu   = {{XLEN{1'b0}}, op_a} * {{XLEN{1'b0}}, op_b};
  assign div_zero = (op_b == '0);
  assign div_ovf  = (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
`endif

  // EX: single-cycle ALU
  always_comb begin
    ALU_OUT = '0;
    if (ex_ctrl.alu_sel[5]) begin
`ifdef RV32M_EN
      case (ex_f3)
        3'b000: ALU_OUT = mul_ss[XLEN-1:0];
        3'b001: ALU_OUT = mul_ss[2*XLEN-1:XLEN];
        3'b010: ALU_OUT = mul_su[2*XLEN-1:XLEN];
        3'b011: ALU_OUT = mul_uu[2*XLEN-1:XLEN];
        3'b100: ALU_OUT = div_zero ? 32'hFFFF_FFFF :
                          div_ovf  ? 32'h8000_0000 : 32'($signed(op_a) / $signed(op_b));
        3'b101: ALU_OUT = div_zero ? 32'hFFFF_FFFF : op_a / op_b;
        3'b110: ALU_OUT = div_zero ? op_a :
                          div_ovf  ? 32'h0 : 32'($signed(op_a) % $signed(op_b));
        default: ALU_OUT = div_zero ? op_a : op_a % op_b;
      endcase
`endif
    end else if (ex_ctrl.alu_sel[3]) begin
      ALU_OUT = op_b;
    end else begin
      case (ex_f3)
        3'b000: ALU_OUT = ex_ctrl.alu_sel[4] ? op_a - op_b : op_a + op_b;
        3'b001: ALU_OUT = op_a << shamt;
        3'b010: ALU_OUT = XLEN'($signed(op_a) < $signed(op_b));
        3'b011: ALU_OUT = XLEN'(op_a < op_b);
        3'b100: ALU_OUT = op_a ^ op_b;
        3'b101: ALU_OUT = ex_ctrl.alu_sel[4] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
        3'b110: ALU_OUT = op_a | op_b;
        default: ALU_OUT = op_a & op_b;
      endcase
    end
  end

  // EX: branch decision on the raw register operands
  always_comb begin
    BRANCH_TAKEN = 1'b0;
    if (ex_ctrl.br_sel[3]) begin
      case (ex_ctrl.br_sel[2:0])
        3'b000: BRANCH_TAKEN = (RS1_DATA == RS2_DATA);
        3'b001: BRANCH_TAKEN = (RS1_DATA != RS2_DATA);
        3'b010: BRANCH_TAKEN = 1'b1;
        3'b100: BRANCH_TAKEN = ($signed(RS1_DATA) <  $signed(RS2_DATA));
        3'b101: BRANCH_TAKEN = ($signed(RS1_DATA) >= $signed(RS2_DATA));
        3'b110: BRANCH_TAKEN = (RS1_DATA <  RS2_DATA);
        3'b111: BRANCH_TAKEN = (RS1_DATA >= RS2_DATA);
        default: BRANCH_TAKEN = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_decode_execute.sv
// Directed testbench for rv32im_decode_execute; M-extension expectations follow RV32M_EN.
module tb_rv32im_decode_execute;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic [31:0] INSTRUCTION;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] PC_EX;
  logic [31:0] IMM_EX;
  logic [3:0]  IMM_SELECT;
  logic [31:0] ALU_OUT;
  logic        BRANCH_TAKEN;
  logic [3:0]  MEM_READ_EX;
  logic [2:0]  MEM_WRITE_EX;
  logic        REG_WRITE_EN_EX;
  logic [1:0]  REG_WRITE_SEL_EX;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI  = 32'h0050_0093;
  localparam logic [31:0] I_LUI   = 32'h1234_50B7;
  localparam logic [31:0] I_AUIPC = 32'h0000_1097;
  localparam logic [31:0] I_SUB   = 32'h4020_81B3;
  localparam logic [31:0] I_SRAI  = 32'h4040_D093;
  localparam logic [31:0] I_SLTU  = 32'h0031_30B3;
  localparam logic [31:0] I_BLT   = 32'h0020_C463;
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;
  localparam logic [31:0] I_SW    = 32'h0020_A023;
  localparam logic [31:0] I_LW    = 32'h0041_2083;
  localparam logic [31:0] I_JAL   = 32'h0080_00EF;
  localparam logic [31:0] I_DIV   = 32'h0220_C1B3;
  localparam logic [31:0] I_DIVU  = 32'h0220_D1B3;
  localparam logic [31:0] I_REM   = 32'h0220_E1B3;
  localparam logic [31:0] I_MULH  = 32'h0220_91B3;
  localparam logic [31:0] I_MULHU = 32'h0220_B1B3;

  rv32im_decode_execute dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .STALL            (STALL),
    .INSTRUCTION      (INSTRUCTION),
    .RS1_DATA         (RS1_DATA),
    .RS2_DATA         (RS2_DATA),
    .PC_EX            (PC_EX),
    .IMM_EX           (IMM_EX),
    .IMM_SELECT       (IMM_SELECT),
    .ALU_OUT          (ALU_OUT),
    .BRANCH_TAKEN     (BRANCH_TAKEN),
    .MEM_READ_EX      (MEM_READ_EX),
    .MEM_WRITE_EX     (MEM_WRITE_EX),
    .REG_WRITE_EN_EX  (REG_WRITE_EN_EX),
    .REG_WRITE_SEL_EX (REG_WRITE_SEL_EX)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Registered controls packed as {mem_read, mem_write, reg_we, reg_wsel}
  task automatic chk_ctrl(input string tag, input logic [3:0] rd, input logic [2:0] wr,
                          input logic we, input logic [1:0] ws);
    chk(tag, 32'({MEM_READ_EX, MEM_WRITE_EX, REG_WRITE_EN_EX, REG_WRITE_SEL_EX}),
        32'({rd, wr, we, ws}));
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    @(negedge CLK);
    INSTRUCTION = instr;
    RS1_DATA    = a;
    RS2_DATA    = b;
    PC_EX       = pc;
    IMM_EX      = imm;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0; INSTRUCTION = '0;
    RS1_DATA = 32'd3; RS2_DATA = 32'd4; PC_EX = '0; IMM_EX = '0;
    #2;
    chk_ctrl("reset_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    chk("reset_bt", 32'(BRANCH_TAKEN), 32'h0);
    chk("reset_alu", ALU_OUT, 32'd7);

    @(negedge CLK);
    RESET = 1'b1;
    drive(I_ADDI, 32'h0, 32'h9, 32'h0, 32'h5);
    chk("addi_immsel", 32'(IMM_SELECT), 32'h1);
    step();
    chk("addi_alu", ALU_OUT, 32'h5);
    chk_ctrl("addi_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);
    chk("addi_bt", 32'(BRANCH_TAKEN), 32'h0);

    drive(I_LUI, 32'h1, 32'h0, 32'h0, 32'h1234_5000);
    chk("lui_immsel", 32'(IMM_SELECT), 32'h4);
    step();
    chk("lui_alu", ALU_OUT, 32'h1234_5000);

    drive(I_AUIPC, 32'h7, 32'h0, 32'h100, 32'h1000);
    step();
    chk("auipc_alu", ALU_OUT, 32'h1100);

    drive(I_SUB, 32'd10, 32'd3, 32'h0, 32'h55);
    step();
    chk("sub_alu", ALU_OUT, 32'd7);

    drive(I_SRAI, 32'h8000_0000, 32'h0, 32'h0, 32'h4);
    step();
    chk("srai_alu", ALU_OUT, 32'hF800_0000);

    drive(I_SLTU, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
    chk("sltu_alu", ALU_OUT, 32'h1);

    // Taken BLT, then the following instruction is squashed
    drive(I_BLT, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
    chk("blt_immsel", 32'(IMM_SELECT), 32'h3);
    step();
    chk("blt_bt", 32'(BRANCH_TAKEN), 32'h1);
    chk("blt_alu", ALU_OUT, 32'h208);
    chk_ctrl("blt_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    drive(I_ADDI, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h8);
    step();
    chk_ctrl("blt_flush_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    chk("blt_flush_bt", 32'(BRANCH_TAKEN), 32'h0);
    chk("blt_flush_alu", ALU_OUT, 32'h0);
    drive(I_ADDI, 32'h0, 32'h0, 32'h0, 32'h5);
    step();
    chk_ctrl("post_flush_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);

    // Taken BEQ under stall: hold, then flush at the first free edge
    drive(I_BEQ, 32'd5, 32'd5, 32'h300, 32'h8);
    step();
    chk("beq_bt", 32'(BRANCH_TAKEN), 32'h1);
    STALL = 1'b1;
    drive(I_ADDI, 32'd5, 32'd5, 32'h300, 32'h8);
    step();
    chk("beq_stall_bt", 32'(BRANCH_TAKEN), 32'h1);
    chk("beq_stall_alu", ALU_OUT, 32'h308);
    @(negedge CLK);
    STALL = 1'b0;
    step();
    chk("beq_flush_bt", 32'(BRANCH_TAKEN), 32'h0);
    chk("beq_flush_alu", ALU_OUT, 32'd10);
    chk_ctrl("beq_flush_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    step();
    chk("beq_next_alu", ALU_OUT, 32'd13);
    chk_ctrl("beq_next_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);

    // Store held by three stalled edges
    STALL = 1'b1;
    drive(I_SW, 32'h1000, 32'h0, 32'h0, 32'h4);
    chk("sw_immsel", 32'(IMM_SELECT), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctrl("sw_stall_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);
    end
    @(negedge CLK);
    STALL = 1'b0;
    step();
    chk_ctrl("sw_ctrl", 4'h0, 3'b110, 1'b0, 2'b00);
    chk("sw_alu", ALU_OUT, 32'h1004);

    // Load, then asynchronous reset mid-cycle
    drive(I_LW, 32'h2000, 32'h0, 32'h0, 32'h4);
    step();
    chk_ctrl("lw_ctrl", 4'b1010, 3'h0, 1'b1, 2'b00);
    chk("lw_alu", ALU_OUT, 32'h2004);
    #2;
    RS1_DATA = 32'd2; RS2_DATA = 32'd3;
    RESET = 1'b0;
    #1;
    chk_ctrl("lw_areset_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    chk("lw_areset_alu", ALU_OUT, 32'd5);
    @(negedge CLK);
    RESET = 1'b1;

    // Jump, then asynchronous reset while the flush request is up
    drive(I_JAL, 32'h0, 32'h0, 32'h400, 32'h8);
    chk("jal_immsel", 32'(IMM_SELECT), 32'h5);
    step();
    chk("jal_bt", 32'(BRANCH_TAKEN), 32'h1);
    chk("jal_alu", ALU_OUT, 32'h408);
    chk_ctrl("jal_ctrl", 4'h0, 3'h0, 1'b1, 2'b11);
    #2;
    RESET = 1'b0;
    #1;
    chk("jal_areset_bt", 32'(BRANCH_TAKEN), 32'h0);
    chk_ctrl("jal_areset_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
    step();
    chk("reset_held_bt", 32'(BRANCH_TAKEN), 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // M extension (bubble + operand sum when disabled)
    drive(I_DIV, 32'd7, 32'd0, 32'h0, 32'h0);
    step();
`ifdef RV32M_EN
    chk("div0_alu", ALU_OUT, 32'hFFFF_FFFF);
    chk_ctrl("div_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);
`else
    chk("div0_alu", ALU_OUT, 32'd7);
    chk_ctrl("div_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
`endif

    drive(I_REM, 32'd7, 32'd0, 32'h0, 32'h0);
    step();
    chk("rem0_alu", ALU_OUT, 32'd7);

    drive(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
`ifdef RV32M_EN
    chk("div_ovf_alu", ALU_OUT, 32'h8000_0000);
`else
    chk("div_ovf_alu", ALU_OUT, 32'h7FFF_FFFF);
`endif

    drive(I_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
`ifdef RV32M_EN
    chk("rem_ovf_alu", ALU_OUT, 32'h0);
`else
    chk("rem_ovf_alu", ALU_OUT, 32'h7FFF_FFFF);
`endif

    drive(I_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step();
    chk("mulhu_alu", ALU_OUT, 32'hFFFF_FFFE);
`ifdef RV32M_EN
    chk_ctrl("mulhu_ctrl", 4'h0, 3'h0, 1'b1, 2'b01);
`else
    chk_ctrl("mulhu_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);
`endif

    drive(I_MULH, 32'h8000_0000, 32'd2, 32'h0, 32'h0);
    step();
`ifdef RV32M_EN
    chk("mulh_alu", ALU_OUT, 32'hFFFF_FFFF);
`else
    chk("mulh_alu", ALU_OUT, 32'h8000_0002);
`endif

    drive(I_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
    step();
`ifdef RV32M_EN
    chk("divu_alu", ALU_OUT, 32'h7FFF_FFFF);
`else
    chk("divu_alu", ALU_OUT, 32'h0000_0001);
`endif

    drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("zero_immsel", 32'(IMM_SELECT), 32'h0);
    step();
    chk_ctrl("zero_ctrl", 4'h0, 3'h0, 1'b0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
